// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache.
// Sits between the MEM stage and a slow line-wide memory with a req/ack
// handshake. Hits complete without stall. A miss freezes the pipeline while
// a dirty victim is written back and the line is refilled. The retried
// access then hits.
module dcache_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITEBACK  = 2'd1,
    READMISS   = 2'd2,
    READMISSOK = 2'd3
  } state_e;

  state_e state_r;
  state_e state_nxt_s;

  logic [LINES-1:0]    valid_r;
  logic [LINES-1:0]    dirty_r;
  logic [TAG_BITS-1:0] tag_r  [LINES];
  logic [255:0]        line_r [LINES];

  logic [INDEX_BITS-1:0] index_s;
  logic [2:0]            word_s;
  logic [TAG_BITS-1:0]   req_tag_s;
  logic                  req_s;
  logic                  hit_s;
  logic                  victim_dirty_s;
  logic                  write_hit_s;
  logic                  refill_s;
  logic [255:0]          cur_line_s;
  logic [255:0]          merged_line_s;
  logic [31:0]           cur_word_s;

  logic                  mem_enable_nxt_s;
  logic                  mem_write_nxt_s;
  logic [31:0]           mem_addr_nxt_s;
  logic [255:0]          mem_data_nxt_s;

  // Byte-offset bits are not needed: every access is a whole word.
  logic                  unused_addr_s;
  assign unused_addr_s = ^cpu_addr_i[1:0];

  assign index_s        = cpu_addr_i[INDEX_BITS+4:5];
  assign word_s         = cpu_addr_i[4:2];
  assign req_tag_s      = cpu_addr_i[31:INDEX_BITS+5];
  assign req_s          = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit_s          = valid_r[index_s] && (tag_r[index_s] == req_tag_s);
  assign victim_dirty_s = valid_r[index_s] && dirty_r[index_s];
  assign cur_line_s     = line_r[index_s];
  assign cur_word_s     = cur_line_s[{word_s, 5'd0} +: 32];
  assign write_hit_s    = (state_r == IDLE) && cpu_MemWrite_i && hit_s;
  assign refill_s       = (state_r == READMISS) && mem_ack_i;

  // Store data merged into the resident line at the selected word.
  always_comb begin
    merged_line_s = cur_line_s;
    merged_line_s[{word_s, 5'd0} +: 32] = cpu_data_i;
  end

  // CPU-side stall and load data, decoded from state and hit.
  always_comb begin
    cpu_stall_o = 1'b1;
    cpu_data_o  = 32'd0;
    case (state_r)
      IDLE: begin
        if (req_s && !hit_s) begin
          cpu_stall_o = 1'b1;
        end else begin
          cpu_stall_o = 1'b0;
        end
        // A simultaneous read and write counts as a write: no load data.
        if (cpu_MemRead_i && !cpu_MemWrite_i && hit_s) begin
          cpu_data_o = cur_word_s;
        end else begin
          cpu_data_o = 32'd0;
        end
      end
      default: begin
        cpu_stall_o = 1'b1;
        cpu_data_o  = 32'd0;
      end
    endcase
  end

  // Next state, and the memory request that the next state will present.
  always_comb begin
    state_nxt_s      = state_r;
    mem_enable_nxt_s = 1'b0;
    mem_write_nxt_s  = 1'b0;
    mem_addr_nxt_s   = 32'd0;
    mem_data_nxt_s   = 256'd0;
    case (state_r)
      IDLE: begin
        if (req_s && !hit_s) begin
          if (victim_dirty_s) begin
            state_nxt_s = WRITEBACK;
          end else begin
            state_nxt_s = READMISS;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_nxt_s = READMISS;
        end else begin
          state_nxt_s = WRITEBACK;
        end
      end
      READMISS: begin
        if (mem_ack_i) begin
          state_nxt_s = READMISSOK;
        end else begin
          state_nxt_s = READMISS;
        end
      end
      READMISSOK: state_nxt_s = IDLE;
      default:    state_nxt_s = IDLE;
    endcase
    // Victim tag is stable during write-back because the CPU inputs are frozen.
    case (state_nxt_s)
      WRITEBACK: begin
        mem_enable_nxt_s = 1'b1;
        mem_write_nxt_s  = 1'b1;
        mem_addr_nxt_s   = {tag_r[index_s], index_s, 5'd0};
        mem_data_nxt_s   = cur_line_s;
      end
      READMISS: begin
        mem_enable_nxt_s = 1'b1;
        mem_write_nxt_s  = 1'b0;
        mem_addr_nxt_s   = {req_tag_s, index_s, 5'd0};
        mem_data_nxt_s   = 256'd0;
      end
      default: begin
        mem_enable_nxt_s = 1'b0;
        mem_write_nxt_s  = 1'b0;
        mem_addr_nxt_s   = 32'd0;
        mem_data_nxt_s   = 256'd0;
      end
    endcase
  end

  // State register and registered memory request; reset drops the request at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= 32'd0;
      mem_data_o   <= 256'd0;
    end else begin
      state_r      <= state_nxt_s;
      mem_enable_o <= mem_enable_nxt_s;
      mem_write_o  <= mem_write_nxt_s;
      mem_addr_o   <= mem_addr_nxt_s;
      mem_data_o   <= mem_data_nxt_s;
    end
  end

  // Valid/dirty bookkeeping: refill installs a clean line, a store hit dirties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (refill_s) begin
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= 1'b0;
    end else if (write_hit_s) begin
      dirty_r[index_s] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (refill_s) begin
      tag_r[index_s]  <= req_tag_s;
      line_r[index_s] <= mem_data_i;
    end else if (write_hit_s) begin
      line_r[index_s] <= merged_line_s;
    end
  end

endmodule
